usb_link_ctrl: RTL and testbench

USB_LINK_CTRL -- requirements
Module: usb_link_ctrl

---
 rtl/usb_pkg.sv | 28 ++
 rtl/usb_sync2.sv | 24 ++
 rtl/usb_link_ctrl.sv | 130 +++++++++++++
 tb/tb_usb_link_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB link-layer definitions: bus line-state codes and link FSM
// state encodings, reused by the link controller and the packet receiver.
package usb_pkg;

  // Synchronized bus line state, packed as {d_n, d_p}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_J   = 2'b01,
    LS_K   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

  // Link controller state encoding, visible on link_state.
  typedef enum logic [2:0] {
    ST_DETACHED  = 3'd0,
    ST_ATTACHED  = 3'd1,
    ST_BUS_RESET = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_SUSPEND   = 3'd4,
    ST_RESUME    = 3'd5
  } link_state_e;

  // Larger of two cycle counts; sizes the shared run counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_sync2.sv
// Two-flop synchronizer for one raw, asynchronous USB data line.
module usb_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk48,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_link_ctrl.sv
// USB device link controller: attach timing, bus reset / suspend / resume
// detection from the synchronized line state, and pullup control.
module usb_link_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned ATTACH_CYC  = 48000,
  parameter int unsigned RESET_CYC   = 120,
  parameter int unsigned SUSPEND_CYC = 144000
) (
  input  logic       clk48,
  input  logic       rst_n,
  input  logic       usb_d_p,
  input  logic       usb_d_n,
  input  logic       soft_detach,
  output logic       usb_pullup,
  output logic [1:0] line_state,
  output logic       rx_enable,
  output logic       bus_reset,
  output logic       suspended,
  output logic [2:0] link_state
);

  localparam int unsigned CNT_MAX = max_u(ATTACH_CYC, SUSPEND_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] ATTACH_LAST  = CNT_W'(ATTACH_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] SUSPEND_LAST = CNT_W'(SUSPEND_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  logic        sync_p;
  logic        sync_n;
  logic [1:0]  sync_ls;
  line_state_e ls_q;
  logic        line_change;
  logic [CNT_W-1:0] cnt;

  link_state_e state_q;
  link_state_e state_d;

  logic se0_run;
  logic j_run;
  logic attach_done;

  // Idle bus is J, so the synchronizer resets to d_p=1, d_n=0.
  usb_sync2 #(.RESET_VAL(1'b1)) u_sync_p (
    .clk48 (clk48),
    .rst_n (rst_n),
    .d     (usb_d_p),
    .q     (sync_p)
  );

  usb_sync2 #(.RESET_VAL(1'b0)) u_sync_n (
    .clk48 (clk48),
    .rst_n (rst_n),
    .d     (usb_d_n),
    .q     (sync_n)
  );

  assign sync_ls     = {sync_n, sync_p};
  assign line_change = (sync_ls != ls_q);

  // cnt holds the number of cycles the current line_state value has been
  // held, minus one; a run "reaches N" when cnt >= N-1. While detached it
  // counts elapsed cycles instead, ignoring line changes.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      ls_q <= LS_J;
      cnt  <= '0;
    end else begin
      ls_q <= line_state_e'(sync_ls);
      if (soft_detach) begin
        cnt <= '0;
      end else if ((state_q != ST_DETACHED) && line_change) begin
        cnt <= '0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  assign se0_run     = (ls_q == LS_SE0) && (cnt >= RESET_LAST);
  assign j_run       = (ls_q == LS_J)   && (cnt >= SUSPEND_LAST);
  assign attach_done = (cnt >= ATTACH_LAST);

  // Link state register.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DETACHED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; soft_detach overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (soft_detach) begin
      state_d = ST_DETACHED;
    end else begin
      case (state_q)
        ST_DETACHED:  if (attach_done) state_d = ST_ATTACHED;
        ST_ATTACHED:  if (se0_run)     state_d = ST_BUS_RESET;
        ST_BUS_RESET: if ((ls_q == LS_J) || (ls_q == LS_K)) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (se0_run)    state_d = ST_BUS_RESET;
          else if (j_run) state_d = ST_SUSPEND;
        end
        ST_SUSPEND: begin
          if (ls_q == LS_K) state_d = ST_RESUME;
          else if (se0_run) state_d = ST_BUS_RESET;
        end
        ST_RESUME: begin
          if (ls_q == LS_J) state_d = ST_ACTIVE;
          else if (se0_run) state_d = ST_BUS_RESET;
        end
        default: state_d = ST_DETACHED;
      endcase
    end
  end

  assign usb_pullup = (state_q != ST_DETACHED);
  assign rx_enable  = (state_q == ST_ACTIVE);
  assign bus_reset  = (state_q == ST_BUS_RESET);
  assign suspended  = (state_q == ST_SUSPEND);
  assign link_state = state_q;
  assign line_state = ls_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// Self-checking bench for usb_link_ctrl: directed vector table, hand-written
// reset/SE1 sequences and randomized line activity against a reference model.
module tb_usb_link_ctrl;

  localparam int unsigned A_CYC = 48;
  localparam int unsigned R_CYC = 8;
  localparam int unsigned S_CYC = 32;
  localparam int unsigned M_CYC = 48;

  logic       clk48       = 1'b0;
  logic       rst_n       = 1'b1;
  logic       usb_d_p     = 1'b1;
  logic       usb_d_n     = 1'b0;
  logic       soft_detach = 1'b0;
  logic       usb_pullup;
  logic [1:0] line_state;
  logic       rx_enable;
  logic       bus_reset;
  logic       suspended;
  logic [2:0] link_state;

  int checks   = 0;
  int failures = 0;

  usb_link_ctrl #(
    .ATTACH_CYC  (A_CYC),
    .RESET_CYC   (R_CYC),
    .SUSPEND_CYC (S_CYC)
  ) dut (
    .clk48       (clk48),
    .rst_n       (rst_n),
    .usb_d_p     (usb_d_p),
    .usb_d_n     (usb_d_n),
    .soft_detach (soft_detach),
    .usb_pullup  (usb_pullup),
    .line_state  (line_state),
    .rx_enable   (rx_enable),
    .bus_reset   (bus_reset),
    .suspended   (suspended),
    .link_state  (link_state)
  );

  always #5 clk48 = ~clk48;

  // Reference model: states numbered as the spec lists them, line codes {d_n,d_p}.
  int         m_state;
  int         m_elapsed;   // cycles the current line value (or detach wait) has lasted, minus one
  logic [1:0] m_pipe [3];  // pin delay line; m_pipe[2] is the visible line_state

  function automatic void model_reset();
    m_state   = 0;
    m_elapsed = 0;
    for (int i = 0; i < 3; i++) m_pipe[i] = 2'b01;
  endfunction

  function automatic void model_edge(input logic [1:0] pins, input logic sd);
    logic [1:0] ls   = m_pipe[2];
    int         held = m_elapsed + 1;
    bit         se0_long = (ls == 2'b00) && (held >= R_CYC);
    int         nxt  = m_state;
    if (sd) nxt = 0;
    else if (m_state == 0 && held >= A_CYC) nxt = 1;
    else if (m_state == 1 && se0_long) nxt = 2;
    else if (m_state == 2 && (ls == 2'b01 || ls == 2'b10)) nxt = 3;
    else if (m_state == 3 && se0_long) nxt = 2;
    else if (m_state == 3 && ls == 2'b01 && held >= S_CYC) nxt = 4;
    else if (m_state == 4 && ls == 2'b10) nxt = 5;
    else if (m_state == 5 && ls == 2'b01) nxt = 3;
    else if ((m_state == 4 || m_state == 5) && se0_long) nxt = 2;

    if (sd) m_elapsed = 0;
    else if (m_state != 0 && m_pipe[1] != ls) m_elapsed = 0;
    else if (m_elapsed < M_CYC) m_elapsed = m_elapsed + 1;

    m_state   = nxt;
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = pins;
  endfunction

  // Output vectors packed as {line_state, link_state, pullup, rx_enable, bus_reset, suspended}.
  function automatic logic [8:0] model_vec();
    return {m_pipe[2], 3'(m_state), (m_state != 0), (m_state == 3),
            (m_state == 2), (m_state == 4)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {line_state, link_state, usb_pullup, rx_enable, bus_reset, suspended};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {ls,link,pu,rx,br,su}=%b required=%b at t=%0t",
               name, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] code, input logic sd);
    {usb_d_n, usb_d_p} = code;
    soft_detach = sd;
  endtask

  // One clock: advance the model with the pre-edge inputs, then compare.
  task automatic step();
    if (rst_n) model_edge({usb_d_n, usb_d_p}, soft_detach);
    else       model_reset();
    @(posedge clk48);
    #1;
    check("cycle_model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic [1:0] pins;
    logic       sd;
    int         n;
    logic [8:0] exp;
    string      name;
  } tv_t;

  localparam int NTV = 20;
  tv_t tv [NTV];

  initial begin
    // Starts in ATTACHED with an idle J line.
    tv[0]  = '{2'b00, 1'b0,  2, 9'b01_001_1000, "se0_in_pipe"};
    tv[1]  = '{2'b00, 1'b0,  8, 9'b00_001_1000, "se0_run_short_of_reset"};
    tv[2]  = '{2'b01, 1'b0,  1, 9'b00_010_1010, "bus_reset_entered"};
    tv[3]  = '{2'b01, 1'b0,  2, 9'b01_010_1010, "bus_reset_until_j"};
    tv[4]  = '{2'b01, 1'b0,  1, 9'b01_011_1100, "active_after_reset"};
    tv[5]  = '{2'b00, 1'b0,  6, 9'b00_011_1100, "se0_6_no_reset"};
    tv[6]  = '{2'b01, 1'b0, 30, 9'b01_011_1100, "j_run_30"};
    tv[7]  = '{2'b01, 1'b0,  4, 9'b01_011_1100, "j_run_31_still_active"};
    tv[8]  = '{2'b01, 1'b0,  1, 9'b01_100_1001, "suspend_at_32"};
    tv[9]  = '{2'b10, 1'b0,  3, 9'b10_100_1001, "k_reaches_line"};
    tv[10] = '{2'b10, 1'b0,  1, 9'b10_101_1000, "resume_on_k"};
    tv[11] = '{2'b10, 1'b0, 16, 9'b10_101_1000, "resume_holds_k"};
    tv[12] = '{2'b00, 1'b0,  2, 9'b10_101_1000, "resume_se0_pending"};
    tv[13] = '{2'b01, 1'b0,  2, 9'b00_101_1000, "resume_holds_se0"};
    tv[14] = '{2'b01, 1'b0,  1, 9'b01_101_1000, "resume_sees_j"};
    tv[15] = '{2'b01, 1'b0,  1, 9'b01_011_1100, "active_after_resume"};
    tv[16] = '{2'b00, 1'b0, 10, 9'b00_011_1100, "se0_run_8_pending"};
    tv[17] = '{2'b00, 1'b1,  1, 9'b00_000_0000, "soft_detach_beats_reset"};
    tv[18] = '{2'b01, 1'b0, 47, 9'b01_000_0000, "reattach_wait_47"};
    tv[19] = '{2'b01, 1'b0,  1, 9'b01_001_1000, "reattach_at_48"};

    // Power-on reset and attach timing.
    model_reset();
    #1 rst_n = 1'b0;
    #1 check("reset_state", dut_vec(), 9'b01_000_0000);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (47) step();
    check("attach_47_no_pullup", dut_vec(), 9'b01_000_0000);
    step();
    check("attach_48_pullup", dut_vec(), 9'b01_001_1000);

    // Directed vector table.
    for (int i = 0; i < NTV; i++) begin
      drive(tv[i].pins, tv[i].sd);
      for (int k = 0; k < tv[i].n; k++) step();
      check(tv[i].name, dut_vec(), tv[i].exp);
    end

    // Reach SUSPEND, show SE1 is inert, then reset asynchronously mid-cycle.
    drive(2'b00, 1'b0);
    repeat (10) step();
    drive(2'b01, 1'b0);
    repeat (40) step();
    check("suspend_reached", dut_vec(), 9'b01_100_1001);
    drive(2'b11, 1'b0);
    repeat (20) step();
    check("se1_in_suspend_inert", dut_vec(), 9'b11_100_1001);
    #3 rst_n = 1'b0;
    model_reset();
    #1 check("async_reset_mid_suspend", dut_vec(), 9'b01_000_0000);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    check("se1_after_reset_detached", dut_vec(), 9'b11_000_0000);

    // Randomized line activity against the reference model.
    for (int seg = 0; seg < 150; seg++) begin
      int unsigned r   = $urandom_range(0, 99);
      logic [1:0]  sym = (r < 40) ? 2'b01 : (r < 60) ? 2'b10 : (r < 85) ? 2'b00 : 2'b11;
      int unsigned len = (sym == 2'b01) ? $urandom_range(1, 60) : $urandom_range(1, 16);
      for (int unsigned k = 0; k < len; k++) begin
        drive(sym, ($urandom_range(0, 199) == 0));
        step();
      end
      if ($urandom_range(0, 29) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("random_async_reset", dut_vec(), 9'b01_000_0000);
        step();
        rst_n = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
